// File: rtl/experiment_sequencer_pkg.sv
// Shared types for the experiment sequencer: parameter set, sequencer states and status codes.
package experiment_sequencer_pkg;

  typedef struct packed {
    logic [15:0] pulse_width;
    logic [15:0] delay_cycles;
    logic [7:0]  gain;
  } parameters_t;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    WAIT_SHOT,
    COOLDOWN,
    DONE,
    ABORT
  } seq_state_t;

  typedef enum logic [2:0] {
    OK,
    CFG_ERR,
    SHOT_ERR,
    ABORTED,
    WDOG
  } seq_status_t;

endpackage

// File: rtl/experiment_sequencer_seq_timer.sv
// Loadable down-counter with zero flag; one instance is shared by every timed sequencer phase.
module experiment_sequencer_seq_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/experiment_sequencer.sv
// Shot scheduler in front of the experiment FSM: latches a run, sequences reset/start/cooldown per shot.
// Optional per-shot watchdog enabled by defining SEQ_WATCHDOG_EN.
module experiment_sequencer
  import experiment_sequencer_pkg::*;
#(
  parameter int unsigned SHOT_W        = 8,
  parameter int unsigned COOL_W        = 32,
  parameter int unsigned FSM_RESET_LEN = 4,
  parameter int unsigned START_LEN     = 2
`ifdef SEQ_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES   = 8_000_000
`endif
) (
  input  logic              clock,
  input  logic              reset_signal,
  input  logic              run_req,
  input  logic              abort_req,
  input  logic [SHOT_W-1:0] shot_count,
  input  logic [COOL_W-1:0] cooldown_cycles,
  input  parameters_t       par_in,
  input  logic              shot_done,
  input  logic              shot_error,
  output parameters_t       par_out,
  output logic              fsm_reset,
  output logic              fsm_start,
  output logic              busy,
  output logic [SHOT_W-1:0] shots_done,
  output logic              run_done,
  output seq_status_t       status,
  output seq_state_t        seq_state
);

  seq_state_t        state, next_state;
  seq_status_t       next_status;
  logic [SHOT_W-1:0] target, next_shots;
  logic [COOL_W-1:0] cooldown, timer_value;
  logic              timer_load, timer_enable, timer_zero, accept;

  assign accept       = (state == IDLE) && run_req && (shot_count != '0);
  assign timer_load   = (next_state != state);
  assign timer_enable = (state != IDLE);
  assign seq_state    = state;

  experiment_sequencer_seq_timer #(
    .WIDTH(COOL_W)
  ) u_seq_timer (
    .clock       (clock),
    .reset_signal(reset_signal),
    .load        (timer_load),
    .enable      (timer_enable),
    .load_value  (timer_value),
    .zero        (timer_zero)
  );

  always_comb begin
    next_state  = state;
    next_status = status;
    next_shots  = shots_done;
    timer_value = '0;

    case (state)
      IDLE: begin
        if (run_req) begin
          if (shot_count != '0) begin
            next_state  = ARM;
            next_status = OK;
            next_shots  = '0;
          end else begin
            next_status = CFG_ERR;
          end
        end
      end
      ARM:   if (timer_zero) next_state = START;
      START: if (timer_zero) next_state = WAIT_SHOT;
      WAIT_SHOT: begin
        if (shot_error) begin
          next_status = SHOT_ERR;
          next_state  = ABORT;
        end else if (shot_done) begin
          next_shots = shots_done + SHOT_W'(1);
          if (next_shots == target)   next_state = DONE;
          else if (cooldown == '0)    next_state = ARM;
          else                        next_state = COOLDOWN;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (timer_zero) begin
          next_status = WDOG;
          next_state  = ABORT;
        end
`endif
      end
      COOLDOWN: if (timer_zero) next_state = ARM;
      DONE:     next_state = IDLE;
      ABORT:    next_state = IDLE;
      default:  next_state = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle shot_done, which is not counted.
    if (abort_req && state != IDLE && state != ABORT) begin
      next_state  = ABORT;
      next_status = ABORTED;
      next_shots  = shots_done;
    end

    // Timer is loaded on every state entry; load value is "phase length minus one".
    case (next_state)
      ARM:       timer_value = COOL_W'(FSM_RESET_LEN - 1);
      START:     timer_value = COOL_W'(START_LEN - 1);
      COOLDOWN:  timer_value = cooldown - COOL_W'(1);
`ifdef SEQ_WATCHDOG_EN
      WAIT_SHOT: timer_value = COOL_W'(WDOG_CYCLES - 1);
`endif
      default:   timer_value = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      state      <= IDLE;
      status     <= OK;
      shots_done <= '0;
      par_out    <= '0;
      target     <= '0;
      cooldown   <= '0;
      fsm_reset  <= 1'b1;
      fsm_start  <= 1'b0;
      busy       <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      state      <= next_state;
      status     <= next_status;
      shots_done <= next_shots;
      // Outputs decoded from next_state so they line up with the registered state.
      fsm_reset  <= !(next_state == START || next_state == WAIT_SHOT);
      fsm_start  <= (next_state == START);
      busy       <= (next_state != IDLE);
      run_done   <= (next_state == DONE);
      if (accept) begin
        target   <= shot_count;
        cooldown <= cooldown_cycles;
        par_out  <= par_in;
      end
    end
  end

endmodule

// File: doc/experiment_sequencer.md
Name: experiment_sequencer

Overview:
- Scheduler in front of fsm_experiment_phase.
- Latches a parameters_t set on a run command and holds it stable for the whole run.
- Runs a programmed number of experiment shots back-to-back. For each shot it resets the experiment FSM, pulses its start, waits for shot completion, then enforces an inter-shot cooldown.
- Reports progress, completion and abort/error status to the host-side register block.

Parameters:
- SHOT_W, 8, width of shot counters (max 255 shots per run).
- COOL_W, 32, width of cooldown counter in clock cycles (5 ns/cycle).
- FSM_RESET_LEN, 4, cycles fsm_reset is held high before each shot.
- START_LEN, 2, cycles fsm_start is held high per shot.
- WDOG_CYCLES, 8_000_000, per-shot watchdog limit (40 ms); used only with the optional feature.

Ports:
- clock  in  1  system clock, 200 MHz.
- reset_signal  in  1  asynchronous, active-high reset.
- run_req  in  1  one-cycle run command.
- abort_req  in  1  one-cycle abort command.
- shot_count  in  SHOT_W  shots requested, sampled on run_req.
- cooldown_cycles  in  COOL_W  inter-shot gap, sampled on run_req.
- par_in  in  parameters_t  experiment parameters, sampled on run_req.
- shot_done  in  1  one-cycle pulse from experiment FSM, shot finished.
- shot_error  in  1  one-cycle pulse from experiment FSM, shot failed (e.g. detector-ready timeout).
- par_out  out  parameters_t  latched parameters to the experiment FSM.
- fsm_reset  out  1  reset to the experiment FSM.
- fsm_start  out  1  start to the experiment FSM.
- busy  out  1  high in every state except IDLE.
- shots_done  out  SHOT_W  completed-shot count of the current/last run.
- run_done  out  1  one-cycle pulse when a run completes normally.
- status  out  seq_status_t  OK / CFG_ERR / SHOT_ERR / ABORTED / WDOG, sticky until next accepted run_req.
- seq_state  out  seq_state_t  current state, for debug/readback.

Behaviour:
- Reset values (asynchronous): state IDLE; par_out '0; fsm_reset 1; fsm_start 0; busy 0; shots_done 0; run_done 0; status OK.
- All outputs are registered.
- IDLE:
  - fsm_reset=1.
  - On run_req with shot_count≠0: latch shot_count, cooldown_cycles and par_in; clear shots_done; status=OK; go ARM.
  - On run_req with shot_count=0: stay IDLE; status=CFG_ERR.
- ARM: fsm_reset=1 for FSM_RESET_LEN cycles, then START.
- START: fsm_reset=0, fsm_start=1 for START_LEN cycles, then WAIT_SHOT.
- WAIT_SHOT: fsm_start=0; exits on the first event below.
  - shot_error: status=SHOT_ERR; go ABORT.
  - shot_done: shots_done+1. If the new count equals the target, go DONE; else go COOLDOWN.
- COOLDOWN:
  - fsm_reset=1.
  - Counts cooldown_cycles cycles, then goes to ARM.
  - cooldown_cycles=0 means ARM on the next cycle.
- DONE: run_done=1 for one cycle; go IDLE. par_out stays latched.
- ABORT: fsm_reset=1, fsm_start=0 for one cycle; go IDLE.
- abort_req in any non-IDLE state: status=ABORTED; go ABORT on the next edge. abort_req in IDLE is ignored.
- Priority in one cycle: abort_req > shot_error > shot_done. A shot_done coinciding with abort or error is not counted.
- run_req while busy is ignored; latched values are unchanged.
- shot_done/shot_error outside WAIT_SHOT are ignored.
- Counter wrap is impossible: target ≤ 2^SHOT_W−1 and the counter stops at the target.
- Reset mid-run returns immediately to reset values; no run_done pulse.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Defined: WAIT_SHOT runs a cycle counter cleared on entry. On reaching WDOG_CYCLES with no shot_done/shot_error, status=WDOG and the block goes to ABORT.
- Undefined: no counter is synthesized, and WAIT_SHOT waits indefinitely.

Decomposition:
- types_pkg additions:
  - seq_state_t enum {IDLE, ARM, START, WAIT_SHOT, COOLDOWN, DONE, ABORT}.
  - seq_status_t enum {OK, CFG_ERR, SHOT_ERR, ABORTED, WDOG}.
  - Reuses the existing parameters_t.
- One sub-module: seq_timer. Loadable down-counter, parameterized width, with load/enable/zero flag. Shared by ARM, START, COOLDOWN and the watchdog.

Test Plan:
- Normal run:
  - Stimulus: shot_count=3, cooldown=100; shot_done pulsed 50 cycles after each fsm_start fall.
  - Response: exactly 3 fsm_start pulses of 2 cycles, each preceded by 4 cycles of fsm_reset; start-to-start spacing ≥100 cooldown cycles; shots_done=3; one run_done; status OK.
- shot_count=0 → stays IDLE, busy=0, status=CFG_ERR. A following valid run_req clears it to OK.
- Shot error: shot_error on shot 2 of 5 → status=SHOT_ERR, shots_done=1, ABORT one cycle then IDLE, no run_done.
- Abort collision: abort_req in the same cycle as shot_done of shot 1 → status=ABORTED, shots_done=0, busy falls within 2 cycles.
- Ignored re-run: run_req with different par_in while busy → par_out unchanged, run continues.
- Watchdog (SEQ_WATCHDOG_EN, WDOG_CYCLES=1000): no shot_done → status=WDOG exactly 1000 cycles after WAIT_SHOT entry. Without the macro, the block stays in WAIT_SHOT.
- Asynchronous reset asserted mid-COOLDOWN → all outputs at reset values with no clock edge.
